// File: rtl/serial_tx_if.sv
// serial_tx_if -- byte handshake into the serial transmitter FIFO.
//   din        byte to enqueue
//   din_valid  din holds a byte to enqueue
//   din_ready  FIFO can accept a byte this cycle (registered in the slave)
// The master modport is used by the byte source, the slave modport by serial_tx.
interface serial_tx_if;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;

  modport master (output din, output din_valid, input din_ready);
  modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/serial_tx.sv
// serial_tx -- FIFO-buffered asynchronous serial transmitter (8N1, or 8E1).
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-low reset
//   s_if        serial_tx_if.slave: din / din_valid in, din_ready out
//   txd         serial line, idle high, LSB first, registered
//   busy        frame in progress or FIFO non-empty
//   fifo_count  bytes queued, excluding the byte being shifted
//
// Parameters:
//   CLK_DIV     clk cycles per serial bit (2..65535)
//   FIFO_AW     log2 of the transmit FIFO depth
//
// Build option:
//   SERIAL_TX_PARITY_EN  when defined, an even parity bit is sent between the
//                        last data bit and the stop bit (11-bit frames).
module serial_tx #(
  parameter int CLK_DIV = 497,
  parameter int FIFO_AW = 4
) (
  input  logic               clk,
  input  logic               reset,
  serial_tx_if.slave         s_if,
  output logic               txd,
  output logic               busy,
  output logic [FIFO_AW:0]   fifo_count
);

  localparam int              DEPTH     = 1 << FIFO_AW;
  localparam logic [15:0]     BAUD_LAST = 16'(CLK_DIV - 1);
  localparam logic [FIFO_AW:0] FULL     = {1'b1, {FIFO_AW{1'b0}}};

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  // FIFO storage and bookkeeping
  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q;
  logic [FIFO_AW-1:0] rd_ptr_q;
  logic [FIFO_AW:0]   count_q;
  logic [FIFO_AW:0]   count_d;
  logic               ready_q;

  // Transmit FSM state
  state_t             state_q;
  logic [15:0]        baud_q;
  logic [2:0]         bit_q;
  logic [7:0]         shift_q;
  logic               txd_q;
`ifdef SERIAL_TX_PARITY_EN
  logic               parity_q;
`endif

  logic               baud_end;
  logic               enq;
  logic               deq;
  logic [7:0]         head;

  always_comb begin
    baud_end = (baud_q == BAUD_LAST);
    enq      = s_if.din_valid && ready_q;
    // A byte leaves the FIFO when the line is free: from IDLE, or on the last
    // stop-bit cycle so the next start bit follows with no gap.
    deq      = (count_q != '0) &&
               ((state_q == IDLE) || ((state_q == STOP) && baud_end));
    head     = mem_q[rd_ptr_q];
    count_d  = count_q;
    if (enq && !deq) begin
      count_d = count_q + 1'b1;
    end else if (!enq && deq) begin
      count_d = count_q - 1'b1;
    end
  end

  // Memory array carries no reset; stale contents are unreachable once the
  // pointers are cleared.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_q[wr_ptr_q] <= s_if.din;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (enq) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (deq) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
      // Registered so that ready reflects the registered count and never
      // depends on din_valid in the same cycle.
      ready_q <= (count_d < FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          baud_q <= '0;
          txd_q  <= 1'b1;
          if (deq) begin
            shift_q  <= head;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= ^head;
`endif
            state_q  <= START;
            txd_q    <= 1'b0;
          end
        end
        START: begin
          if (baud_end) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= DATA;
            txd_q   <= shift_q[0];
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
              state_q <= PARITY;
              txd_q   <= parity_q;
`else
              state_q <= STOP;
              txd_q   <= 1'b1;
`endif
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= shift_q >> 1;
              // shift_q[1] becomes the new shift_q[0] on this edge
              txd_q   <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        PARITY: begin
          if (baud_end) begin
            baud_q  <= '0;
            state_q <= STOP;
            txd_q   <= 1'b1;
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
`endif
        STOP: begin
          if (baud_end) begin
            baud_q <= '0;
            if (deq) begin
              shift_q  <= head;
`ifdef SERIAL_TX_PARITY_EN
              parity_q <= ^head;
`endif
              state_q  <= START;
              txd_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
              txd_q   <= 1'b1;
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          baud_q  <= '0;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

  assign s_if.din_ready = ready_q;
  assign txd            = txd_q;
  assign busy           = (state_q != IDLE) || (count_q != '0);
  assign fifo_count     = count_q;

endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 Parameter CLK_DIV, default 497, clk cycles per serial bit (57.272 MHz / 115200); legal range 2..65535.
REQ-002 Parameter FIFO_AW, default 4, log2 of transmit FIFO depth (depth = 16).
REQ-003 clk  input  1  system clock (57.272 MHz); all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 din  input  8  byte to transmit.
REQ-006 din_valid  input  1  din holds a byte to enqueue.
REQ-007 din_ready  output  1  FIFO can accept a byte this cycle.
REQ-008 txd  output  1  serial line, idle high, LSB first.
REQ-009 busy  output  1  frame in progress or FIFO non-empty.
REQ-010 fifo_count  output  FIFO_AW+1  bytes currently queued (excluding the byte being shifted).

Function
REQ-011 Byte SHALL be enqueued on a rising edge where din_valid=1 and din_ready=1; no other condition enqueues.
REQ-012 din_ready SHALL be 1 exactly when the registered fifo_count < 2^FIFO_AW; it SHALL NOT depend combinationally on din_valid.
REQ-013 Enqueue and dequeue on the same edge SHALL leave fifo_count unchanged; FIFO pointers SHALL wrap modulo depth.
REQ-014 FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
REQ-015 IDLE: txd=1; if fifo_count>0, dequeue head into shift register and enter START on the same edge.
REQ-016 START: txd=0 for exactly CLK_DIV cycles, then DATA.
REQ-017 DATA: txd=shift[0] for CLK_DIV cycles per bit, 8 bits LSB first, 3-bit bit counter, then PARITY or STOP.
REQ-018 STOP: txd=1 for exactly CLK_DIV cycles; then IDLE, or, if fifo_count>0, dequeue and enter START on the same edge (back-to-back frames, no idle gap).
REQ-019 Baud counter SHALL be 16 bits, reload to 0 on each state/bit change, and advance only while not IDLE.
REQ-020 Latency: byte accepted on edge N into an empty FIFO while IDLE SHALL drive txd=0 after edge N+1.
REQ-021 busy SHALL be 0 only when state=IDLE and fifo_count=0.
REQ-022 txd SHALL be a registered output with no glitches.
REQ-023 Full frame length SHALL be 10*CLK_DIV cycles (11*CLK_DIV with parity).

Reset
REQ-024 While reset=0 at an edge: state=IDLE, txd=1, busy=0, fifo_count=0, din_ready=0, pointers=0, baud counter=0.
REQ-025 din_ready SHALL rise on the first edge after reset returns to 1.
REQ-026 Reset mid-frame SHALL abort the frame, drive txd=1 after the next edge, and discard all queued bytes.

Configuration
REQ-027 Macro SERIAL_TX_PARITY_EN defined: PARITY state inserted after DATA, txd = even parity (XOR of the 8 data bits) for CLK_DIV cycles.
REQ-028 Macro SERIAL_TX_PARITY_EN undefined: no PARITY state, 8N1 framing, no parity logic synthesised.

Verification (bench CLK_DIV=4, FIFO_AW=4)
REQ-029 Reset low 3 cycles mid-frame -> txd=1, fifo_count=0, busy=0 next edge; din_ready=1 one edge after release.
REQ-030 Push 0x55 when idle -> txd 0 at N+1, then 1,0,1,0,1,0,1,0,1 (stop), each held 4 cycles; 40 cycles total; busy falls afterwards.
REQ-031 Push 0xA3,0x0F back-to-back -> two 40-cycle frames with no idle cycle between the stop of frame 1 and the start of frame 2.
REQ-032 Hold din_valid=1 for 20 cycles with txd stalled in the first frame -> 16 bytes queued plus 1 in shift, din_ready=0 at count 16, rejected bytes never appear on txd.
REQ-033 Full FIFO, push asserted as STOP dequeues -> count stays at 16 then accepts the next byte; order preserved across the pointer wrap.
REQ-034 With SERIAL_TX_PARITY_EN, push 0x07 -> parity bit 1, frame length 44 cycles; push 0x03 -> parity bit 0.
